// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared PS/2 definitions for the host transmit path and the keyboard
// receive path: FSM state encodings, well-known command/response bytes,
// the default clock glitch-filter depth and the frame parity helper.
// ---------------------------------------------------------------------------
package ps2_pkg;

  // Host transmitter FSM states.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_INHIBIT  = 3'd1;
  localparam logic [2:0] ST_RTS      = 3'd2;
  localparam logic [2:0] ST_SHIFT    = 3'd3;
  localparam logic [2:0] ST_ACK      = 3'd4;
  localparam logic [2:0] ST_WAIT_REL = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;
  localparam logic [2:0] ST_ERR      = 3'd7;

  // Keyboard command and response bytes.
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  // Number of consecutive equal PS2Clk samples before the filtered level moves.
  localparam int PS2_FILTER_LEN = 8;

  // PS/2 frames carry odd parity over the 8 data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ---------------------------------------------------------------------------
// ps2_line_sync
// Brings the asynchronous PS2Clk and data pads into the clk domain.
// Both lines pass a 2-FF synchroniser; PS2Clk is additionally glitch
// filtered and produces a one-cycle strobe on each filtered falling edge.
// Shared by the host transmitter and the keyboard receiver.
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   clk_pad    in   PS2Clk pad (async)
//   data_pad   in   PS2 data pad (async)
//   clk_filt   out  synchronised, filtered PS2Clk level
//   clk_fall   out  1-cycle strobe: clk_filt went 1 -> 0
//   data_sync  out  synchronised data level
// ---------------------------------------------------------------------------
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_pad,
  input  logic data_pad,
  output logic clk_filt,
  output logic clk_fall,
  output logic data_sync
);

  logic [1:0]            clk_meta;
  logic [1:0]            data_meta;
  logic [FILTER_LEN-1:0] clk_hist;

  // Everything resets to the idle (released, high) line level so that
  // leaving reset never produces a spurious falling-edge strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta  <= '1;
      data_meta <= '1;
      clk_hist  <= '1;
      clk_filt  <= 1'b1;
      clk_fall  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge value of the stage before it, giving a true shift chain.
      clk_meta <= {clk_meta[0], clk_pad};
      data_meta <= {data_meta[0], data_pad};
      clk_hist  <= {clk_hist[FILTER_LEN-2:0], clk_meta[1]};
      clk_fall  <= 1'b0;
      // The filtered level only moves once the whole history agrees.
      if (&clk_hist) begin
        clk_filt <= 1'b1;
      end else if (~|clk_hist) begin
        clk_filt <= 1'b0;
        clk_fall <= clk_filt;
      end
    end
  end

  assign data_sync = data_meta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Inhibits the bus, issues request-to-send,
// shifts out start/8 data/odd parity/stop on device-generated clock edges,
// checks the device ACK and waits for bus release.
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   PS2Clk_in  in   PS2Clk pad input (async)
//   PS2Clk_oe  out  1 = pull PS2Clk low, 0 = release
//   data_in    in   PS2 data pad input (async)
//   data_oe    out  1 = pull data low, 0 = release
//   tx_data    in   command byte, captured when tx_start is accepted
//   tx_start   in   send request, accepted only in IDLE
//   busy       out  high from accept until the DONE/ERR cycle
//   done       out  1-cycle pulse: byte sent and ACK seen
//   err        out  1-cycle pulse: timeout or missing ACK
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  // Must exceed the line-sync latency (~FILTER_LEN+3) so the filtered
  // falling edge caused by our own inhibit lands inside INHIBIT.
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned START_TIMEOUT  = 1500000,
  parameter int unsigned BIT_TIMEOUT    = 200000,
  parameter int          FILTER_LEN     = PS2_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2Clk_in,
  output logic       PS2Clk_oe,
  input  logic       data_in,
  output logic       data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [20:0] INHIBIT_LAST = 21'(INHIBIT_CYCLES - 1);
  // Data is pulled low one cycle before the clock is released.
  localparam logic [20:0] INHIBIT_DATA = 21'(INHIBIT_CYCLES - 2);
  localparam logic [20:0] START_LAST   = 21'(START_TIMEOUT - 1);
  localparam logic [20:0] BIT_LAST     = 21'(BIT_TIMEOUT - 1);

  logic [2:0]  state;
  logic [10:0] frame;     // {stop, par, data[7:0], start}; bit 0 is on the wire
  logic [3:0]  bit_cnt;   // bits driven since the first device clock
  logic [20:0] tmo_cnt;

  logic        clk_filt;
  logic        clk_fall;
  logic        data_sync;

  logic        waiting;
  logic [20:0] tmo_limit;
  logic        released;
  logic        tmo_hit;
  logic        nack;
  logic        abort;

  ps2_line_sync #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_sync (
    .clk       (clk),
    .reset     (reset),
    .clk_pad   (PS2Clk_in),
    .data_pad  (data_in),
    .clk_filt  (clk_filt),
    .clk_fall  (clk_fall),
    .data_sync (data_sync)
  );

  // Abort detection: per-state timeout or a device that did not ACK.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    waiting   = 1'b0;
    tmo_limit = BIT_LAST;
    case (state)
      ST_RTS: begin
        waiting   = 1'b1;
        tmo_limit = START_LAST;
      end
      ST_SHIFT, ST_ACK, ST_WAIT_REL: waiting = 1'b1;
      default: ;
    endcase
    released = clk_filt & data_sync;
    // A device edge or bus release in the expiry cycle still wins.
    tmo_hit  = waiting && (tmo_cnt == tmo_limit) && !clk_fall &&
               !((state == ST_WAIT_REL) && released);
    nack     = (state == ST_ACK) && clk_fall && data_sync;
    abort    = tmo_hit | nack;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      frame     <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      PS2Clk_oe <= 1'b0;
      data_oe   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      tmo_cnt <= tmo_cnt + 21'd1;

      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          bit_cnt <= '0;
          if (tx_start) begin
            frame     <= {1'b1, odd_parity(tx_data), tx_data, 1'b0};
            busy      <= 1'b1;
            PS2Clk_oe <= 1'b1;
            state     <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (tmo_cnt == INHIBIT_LAST) begin
            PS2Clk_oe <= 1'b0;
            tmo_cnt   <= '0;
            state     <= ST_RTS;
          end else if (tmo_cnt == INHIBIT_DATA) begin
            data_oe <= ~frame[0];   // start bit
          end
        end

        // Each device falling edge moves the next frame bit onto the wire.
        ST_RTS, ST_SHIFT: begin
          if (clk_fall) begin
            frame   <= {1'b1, frame[10:1]};
            data_oe <= ~frame[1];
            tmo_cnt <= '0;
            if (state == ST_RTS) begin
              bit_cnt <= 4'd1;
              state   <= ST_SHIFT;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              // The fall driving the stop bit (10th bit) ends shifting.
              if (bit_cnt == 4'd9) state <= ST_ACK;
            end
          end
        end

        ST_ACK: begin
          if (clk_fall && !data_sync) begin
            tmo_cnt <= '0;
            state   <= ST_WAIT_REL;
          end
        end

        ST_WAIT_REL: begin
          if (released) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end
        end

        ST_DONE, ST_ERR: begin
          tmo_cnt <= '0;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase

      // Abort overrides whatever the state decided this cycle.
      if (abort) begin
        err       <= 1'b1;
        busy      <= 1'b0;
        PS2Clk_oe <= 1'b0;
        data_oe   <= 1'b0;
        tmo_cnt   <= '0;
        state     <= ST_ERR;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Keyboard BFM on an open-drain PS2Clk/data pair plus a scoreboard:
// stimulus pushes the expected frame and done/err outcome into queues,
// the BFM compares the frame it clocked in, and a monitor compares each
// done/err pulse against the expected outcome.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INHIBIT   = 20;
  localparam int START_TMO = 500;
  localparam int BIT_TMO   = 200;
  localparam int HALF      = 15;   // device clock high phase halves
  localparam int LOW       = 30;   // device clock low phase

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       PS2Clk_oe, data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, err;

  logic       bfm_clk = 1'b1;
  logic       bfm_data = 1'b1;
  logic       clk_pad, data_pad;

  // Open-drain wired-AND of host and device.
  assign clk_pad  = bfm_clk & ~PS2Clk_oe;
  assign data_pad = bfm_data & ~data_oe;

  int checks = 0;
  int errors = 0;

  bit          exp_result_q[$];   // 1 = done expected, 0 = err expected
  logic [10:0] exp_frame_q[$];    // samples as the device sees them, bit 0 first

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .START_TIMEOUT  (START_TMO),
    .BIT_TIMEOUT    (BIT_TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .PS2Clk_in (clk_pad),
    .PS2Clk_oe (PS2Clk_oe),
    .data_in   (data_pad),
    .data_oe   (data_oe),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Outcome monitor.
  initial begin
    bit exp_done;
    forever begin
      @(negedge clk);
      if (!reset && (done || err)) begin
        if (exp_result_q.size() == 0) begin
          check("unexpected_result", {30'd0, done, err}, 32'd0);
        end else begin
          exp_done = exp_result_q.pop_front();
          check("result_done", done, exp_done);
          check("result_err", err, !exp_done);
          check("result_oe_released", {PS2Clk_oe, data_oe}, 2'b00);
          check("result_busy_low", busy, 1'b0);
        end
      end
    end
  end

  // Inhibit-length monitor: every PS2Clk_oe pulse lasts INHIBIT cycles.
  initial begin
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (PS2Clk_oe) n++;
      else if (n != 0) begin
        check("inhibit_len", n, INHIBIT);
        n = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic start_tx(input logic [7:0] d, input bit par, input bit push_frame,
                          input bit push_result, input bit exp_done);
    if (push_frame)  exp_frame_q.push_back({1'b1, par, d, 1'b0});
    if (push_result) exp_result_q.push_back(exp_done);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("accept_busy", busy, 1'b1);
  endtask

  task automatic wait_rts(output bit ok);
    int n;
    n = 0;
    while (!(!PS2Clk_oe && data_oe && busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 2000);
    if (!ok) check("rts_seen", {30'd0, PS2Clk_oe, data_oe}, 32'b01);
  endtask

  // Device model: waits for RTS, then produces n_falls clock pulses,
  // sampling data in each high phase before the falling edge.
  task automatic bfm_run(input int n_falls, input bit give_ack, input string name);
    logic [10:0] seen;
    bit ok;
    seen = '0;
    wait_rts(ok);
    if (!ok) return;
    repeat (20) @(negedge clk);
    for (int k = 0; k < n_falls; k++) begin
      repeat (HALF) @(negedge clk);
      seen[k] = data_pad;
      if (k == 10 && give_ack) bfm_data = 1'b0;
      repeat (HALF) @(negedge clk);
      bfm_clk = 1'b0;
      repeat (LOW) @(negedge clk);
      bfm_clk  = 1'b1;
      bfm_data = 1'b1;
    end
    if (n_falls == 11) begin
      if (exp_frame_q.size() == 0) check("frame_queue", 0, 1);
      else check(name, {21'd0, seen}, {21'd0, exp_frame_q.pop_front()});
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int n;
    bit ok;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_clk_oe", PS2Clk_oe, 1'b0);
    check("reset_data_oe", data_oe, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: LED command, with a tx_start attempt mid-frame that must be ignored.
    start_tx(CMD_SET_LED, 1'b1, 1'b1, 1'b1, 1'b1);
    fork
      bfm_run(11, 1'b1, "frame_ED");
      begin
        repeat (150) @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    wait_idle();
    repeat (50) @(negedge clk);
    check("no_requeue_busy", busy, 1'b0);
    check("no_requeue_clk_oe", PS2Clk_oe, 1'b0);

    // 2: parity 0 and parity 1 frames.
    start_tx(CMD_ENABLE, 1'b0, 1'b1, 1'b1, 1'b1);
    bfm_run(11, 1'b1, "frame_F4");
    wait_idle();
    start_tx(CMD_RESET, 1'b1, 1'b1, 1'b1, 1'b1);
    bfm_run(11, 1'b1, "frame_FF");
    wait_idle();

    // 3: device never clocks -> err exactly START_TMO cycles after RTS.
    start_tx(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_rts(ok);
    if (ok) begin
      n = 0;
      while (!err && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("start_timeout_cycles", n, START_TMO);
    end
    wait_idle();

    // 4: device withholds ACK.
    start_tx(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    bfm_run(11, 1'b0, "frame_3C");
    wait_idle();

    // 5: device stops after bit 4 -> err ~BIT_TMO after the last pad fall.
    start_tx(8'h81, 1'b1, 1'b0, 1'b1, 1'b0);
    bfm_run(5, 1'b1, "");
    n = 0;
    while (!err && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("bit_timeout_window", ((n + LOW) >= BIT_TMO + 3) && ((n + LOW) <= BIT_TMO + 30), 1'b1);
    wait_idle();

    // 6: reset mid-SHIFT clears outputs immediately; next frame is clean.
    start_tx(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    bfm_run(3, 1'b1, "");
    repeat (5) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    check("pre_reset_data_oe", data_oe, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_clk_oe", PS2Clk_oe, 1'b0);
    check("async_reset_data_oe", data_oe, 1'b0);
    check("async_reset_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    start_tx(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    bfm_run(11, 1'b1, "frame_A5");
    wait_idle();

    repeat (20) @(negedge clk);
    check("result_queue_drained", exp_result_q.size(), 0);
    check("frame_queue_drained", exp_frame_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
